data_unit_mc: RTL and testbench

- Multi-cycle successor to the single-cycle datapath unit.
- Holds the register file and ALU, and talks to an external variable-latency data memory over a req/ack handshake.
- Accepts one decoded operation through a valid/ready handshake, then executes it over several states and writes back.
- Sits between the control/decode unit and the data memory bus.

---
 rtl/data_unit_mc.sv | 247 ++++++++++++++++++++++++
 tb/tb_data_unit_mc.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_unit_mc.sv
// rtl/data_unit_mc.sv - multi-cycle register file + ALU datapath with req/ack data-memory port
//
// Build option: DATA_UNIT_FAST_WB_EN
//   When defined, ops that do not touch memory retire in EXEC (write + done)
//   and return straight to IDLE. Memory ops always go EXEC -> MEM -> WB.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   op_valid/ready  decoded-op handshake; ready only in IDLE
//   AD1, AD2, AD3   rs1, rs2, rd register indices
//   ImmOp, PC       immediate and PC of the op
//   RegWrite        write rd at writeback
//   MemWrite        store (takes priority over ResultSrc == 01)
//   ALUctrl         000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl
//   ALUsrc          operand 2 select: 0 rs2, 1 ImmOp
//   ResultSrc       writeback select: 00 ALU, 01 load, 10 PC+4, 11 ImmOp
//   funct3          load/store size and sign
//   mem_*           data-memory request port, held stable while mem_req is high
//   done            one-cycle retire pulse
//   EQ, ALUout      registered ALU zero flag and result
//   a0              live contents of x10

module data_unit_mc #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     op_valid,
    output logic                     op_ready,
    input  logic [ADDRESS_WIDTH-1:0] AD1,
    input  logic [ADDRESS_WIDTH-1:0] AD2,
    input  logic [ADDRESS_WIDTH-1:0] AD3,
    input  logic [DATA_WIDTH-1:0]    ImmOp,
    input  logic                     RegWrite,
    input  logic                     MemWrite,
    input  logic [2:0]               ALUctrl,
    input  logic                     ALUsrc,
    input  logic [1:0]               ResultSrc,
    input  logic [2:0]               funct3,
    input  logic [DATA_WIDTH-1:0]    PC,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [DATA_WIDTH-1:0]    mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic [2:0]               mem_funct3,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    input  logic                     mem_ack,
    output logic                     done,
    output logic                     EQ,
    output logic [DATA_WIDTH-1:0]    ALUout,
    output logic [DATA_WIDTH-1:0]    a0
);

    localparam int NUM_REGS = 2 ** ADDRESS_WIDTH;
    localparam int SHAMT_W  = $clog2(DATA_WIDTH);
    localparam logic [ADDRESS_WIDTH-1:0] A0_IDX = ADDRESS_WIDTH'(10);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        MEM  = 2'b10,
        WB   = 2'b11
    } state_t;

    state_t state, state_next;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Operation context captured at accept; everything after IDLE works
    // only from these so the decode side is free to move on.
    logic [DATA_WIDTH-1:0]    op_a_q;
    logic [DATA_WIDTH-1:0]    op_b_q;
    logic [DATA_WIDTH-1:0]    rs2_q;
    logic [ADDRESS_WIDTH-1:0] rd_q;
    logic                     regwrite_q;
    logic                     memwrite_q;
    logic [1:0]               resultsrc_q;
    logic [2:0]               funct3_q;
    logic [2:0]               aluctrl_q;
    logic [DATA_WIDTH-1:0]    imm_q;
    logic [DATA_WIDTH-1:0]    pc_q;

    logic [DATA_WIDTH-1:0]    alu_q;
    logic                     eq_q;
    logic [DATA_WIDTH-1:0]    load_q;

    logic [DATA_WIDTH-1:0]    rd1;
    logic [DATA_WIDTH-1:0]    rd2;
    logic [DATA_WIDTH-1:0]    alu_result;
    logic [DATA_WIDTH-1:0]    alu_sel;
    logic [DATA_WIDTH-1:0]    load_ext;
    logic [DATA_WIDTH-1:0]    wb_data;
    logic                     mem_op;
    logic                     wr_en;

    // Combinational register reads; x0 is hard-wired to zero.
    assign rd1 = (AD1 == '0) ? '0 : regs[AD1];
    assign rd2 = (AD2 == '0) ? '0 : regs[AD2];
    assign a0  = regs[A0_IDX];

    // A store wins over ResultSrc == 01, but both need the memory phase.
    assign mem_op = memwrite_q | (resultsrc_q == 2'b01);

    always_comb begin
        alu_result = '0;
        case (aluctrl_q)
            3'b000: alu_result = op_a_q + op_b_q;
            3'b001: alu_result = op_a_q - op_b_q;
            3'b010: alu_result = op_a_q & op_b_q;
            3'b011: alu_result = op_a_q | op_b_q;
            3'b100: alu_result = op_a_q ^ op_b_q;
            3'b101: alu_result = {{(DATA_WIDTH-1){1'b0}},
                                  ($signed(op_a_q) < $signed(op_b_q))};
            3'b110: alu_result = op_a_q << op_b_q[SHAMT_W-1:0];
            3'b111: alu_result = op_a_q >> op_b_q[SHAMT_W-1:0];
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        load_ext = load_q;
        case (funct3_q)
            3'b000:  load_ext = {{(DATA_WIDTH-8){load_q[7]}}, load_q[7:0]};
            3'b001:  load_ext = {{(DATA_WIDTH-16){load_q[15]}}, load_q[15:0]};
            3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, load_q[7:0]};
            3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, load_q[15:0]};
            default: load_ext = load_q;
        endcase
    end

    // In EXEC the registered result is not there yet, so a write made in
    // EXEC (fast writeback) has to take the live ALU output.
    always_comb begin
        alu_sel = (state == EXEC) ? alu_result : alu_q;
        wb_data = alu_sel;
        case (resultsrc_q)
            2'b00:   wb_data = alu_sel;
            2'b01:   wb_data = load_ext;
            2'b10:   wb_data = pc_q + DATA_WIDTH'(4);
            2'b11:   wb_data = imm_q;
            default: wb_data = alu_sel;
        endcase
    end

    always_comb begin
        state_next = state;
        op_ready   = 1'b0;
        done       = 1'b0;
        wr_en      = 1'b0;
        case (state)
            IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (mem_op) begin
                    state_next = MEM;
                end else begin
`ifdef DATA_UNIT_FAST_WB_EN
                    done       = 1'b1;
                    wr_en      = regwrite_q && (rd_q != '0);
                    state_next = IDLE;
`else
                    state_next = WB;
`endif
                end
            end
            MEM: begin
                if (mem_ack) begin
                    state_next = WB;
                end
            end
            WB: begin
                done       = 1'b1;
                wr_en      = regwrite_q && !memwrite_q && (rd_q != '0);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Address and write data come straight from registers, so they are
    // stable for the whole request without extra holding logic.
    assign mem_req    = (state == MEM);
    assign mem_we     = (state == MEM) && memwrite_q;
    assign mem_addr   = alu_q;
    assign mem_wdata  = rs2_q;
    assign mem_funct3 = funct3_q;
    assign ALUout     = alu_q;
    assign EQ         = eq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            regwrite_q  <= 1'b0;
            memwrite_q  <= 1'b0;
            resultsrc_q <= 2'b00;
            funct3_q    <= 3'b000;
            aluctrl_q   <= 3'b000;
            imm_q       <= '0;
            pc_q        <= '0;
            alu_q       <= '0;
            eq_q        <= 1'b0;
            load_q      <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state <= state_next;

            if (state == IDLE && op_valid) begin
                op_a_q      <= rd1;
                op_b_q      <= ALUsrc ? ImmOp : rd2;
                rs2_q       <= rd2;
                rd_q        <= AD3;
                regwrite_q  <= RegWrite;
                memwrite_q  <= MemWrite;
                resultsrc_q <= ResultSrc;
                funct3_q    <= funct3;
                aluctrl_q   <= ALUctrl;
                imm_q       <= ImmOp;
                pc_q        <= PC;
            end

            if (state == EXEC) begin
                alu_q <= alu_result;
                eq_q  <= (alu_result == '0);
            end

            if (state == MEM && mem_ack && !memwrite_q) begin
                load_q <= mem_rdata;
            end

            if (wr_en) begin
                regs[rd_q] <= wb_data;
            end
        end
    end

endmodule

// File: tb/tb_data_unit_mc.sv
// tb/tb_data_unit_mc.sv - randomized self-checking bench for data_unit_mc

module tb_data_unit_mc;

    localparam int DW = 32;
    localparam int AW = 5;

`ifdef DATA_UNIT_FAST_WB_EN
    localparam int ALU_LAT = 1;
`else
    localparam int ALU_LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          op_valid;
    logic          op_ready;
    logic [AW-1:0] AD1, AD2, AD3;
    logic [DW-1:0] ImmOp;
    logic          RegWrite;
    logic          MemWrite;
    logic [2:0]    ALUctrl;
    logic          ALUsrc;
    logic [1:0]    ResultSrc;
    logic [2:0]    funct3;
    logic [DW-1:0] PC;
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    mem_funct3;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          done;
    logic          EQ;
    logic [DW-1:0] ALUout;
    logic [DW-1:0] a0;

    int vectors = 0;
    int errors  = 0;

    logic [DW-1:0] model [0:31];

    always #5 clk = ~clk;

    data_unit_mc #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .AD1(AD1), .AD2(AD2), .AD3(AD3), .ImmOp(ImmOp),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .ALUctrl(ALUctrl),
        .ALUsrc(ALUsrc), .ResultSrc(ResultSrc), .funct3(funct3), .PC(PC),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .done(done),
        .EQ(EQ), .ALUout(ALUout), .a0(a0)
    );

    function automatic logic [31:0] alu_ref(input logic [2:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
        case (c)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6:    return a << b[4:0];
            default: return a >> b[4:0];
        endcase
    endfunction

    function automatic logic [31:0] load_ref(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  return {{24{d[7]}}, d[7:0]};
            3'b001:  return {{16{d[15]}}, d[15:0]};
            3'b100:  return {24'h0, d[7:0]};
            3'b101:  return {16'h0, d[15:0]};
            default: return d;
        endcase
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = '0;
    endtask

    // Issues one op at the current negedge (unit must be idle), plays the
    // memory side, and returns at the first idle negedge after retirement.
    task automatic run_op(
        input logic [2:0] ctrl, input logic src, input logic [1:0] rsrc,
        input logic rw, input logic mw,
        input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
        input logic [31:0] imm, input logic [31:0] pc, input logic [2:0] f3,
        input int req_cycles, input logic [31:0] rdata,
        output logic [31:0] res);
        logic [31:0] va, vb, exp_alu, wbv;
        bit          is_mem, seen;
        int          exp_lat, cyc, nreq;
        va      = model[a1];
        vb      = model[a2];
        exp_alu = alu_ref(ctrl, va, src ? imm : vb);
        is_mem  = mw || (rsrc == 2'b01);
        exp_lat = is_mem ? 2 + req_cycles : ALU_LAT;
        case (rsrc)
            2'b00:   wbv = exp_alu;
            2'b01:   wbv = load_ref(f3, rdata);
            2'b10:   wbv = pc + 32'd4;
            default: wbv = imm;
        endcase

        vectors++;
        if (op_ready !== 1'b1) begin
            errors++;
            $display("FAIL op_ready_idle: got %b expected 1", op_ready);
        end
        AD1 = a1; AD2 = a2; AD3 = a3; ImmOp = imm; PC = pc; funct3 = f3;
        ALUctrl = ctrl; ALUsrc = src; ResultSrc = rsrc; RegWrite = rw; MemWrite = mw;
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid  = 1'b0;
        AD1       = 5'($urandom());
        AD2       = 5'($urandom());
        AD3       = 5'($urandom());
        ImmOp     = $urandom();
        ALUctrl   = 3'($urandom());
        ResultSrc = 2'($urandom());
        RegWrite  = 1'($urandom());
        MemWrite  = 1'($urandom());

        cyc = 0; nreq = 0; seen = 0;
        while (!seen && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (mem_req === 1'b1) begin
                nreq++;
                vectors++;
                if (mem_we !== mw || mem_addr !== exp_alu || mem_wdata !== vb ||
                    mem_funct3 !== f3) begin
                    errors++;
                    $display("FAIL mem_port: got we=%b addr=%h wdata=%h f3=%b expected we=%b addr=%h wdata=%h f3=%b",
                             mem_we, mem_addr, mem_wdata, mem_funct3, mw, exp_alu, vb, f3);
                end
                mem_ack   = (nreq == req_cycles);
                mem_rdata = (nreq == req_cycles) ? rdata : $urandom();
            end else begin
                mem_ack   = 1'($urandom_range(0, 1));
                mem_rdata = $urandom();
            end
            if (done === 1'b1) seen = 1;
        end
        mem_ack = 1'b0;

        vectors++;
        if (!seen || cyc != exp_lat) begin
            errors++;
            $display("FAIL done_latency: got %0d cycles (seen=%0d) expected %0d", cyc, seen, exp_lat);
        end
        vectors++;
        if (nreq != (is_mem ? req_cycles : 0)) begin
            errors++;
            $display("FAIL mem_req_cycles: got %0d expected %0d", nreq, is_mem ? req_cycles : 0);
        end

        if (rw && !mw && a3 != 5'd0) model[a3] = wbv;

        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || op_ready !== 1'b1) begin
            errors++;
            $display("FAIL retire_to_idle: got done=%b op_ready=%b expected done=0 op_ready=1", done, op_ready);
        end
        vectors++;
        if (ALUout !== exp_alu || EQ !== (exp_alu == 32'd0)) begin
            errors++;
            $display("FAIL alu_result: got %h eq=%b expected %h eq=%b", ALUout, EQ, exp_alu, exp_alu == 32'd0);
        end
        vectors++;
        if (a0 !== model[10]) begin
            errors++;
            $display("FAIL a0: got %h expected %h", a0, model[10]);
        end
        res = ALUout;
    endtask

    task automatic probe(input logic [4:0] idx, output logic [31:0] val);
        run_op(3'd0, 1'b1, 2'b00, 1'b0, 1'b0, idx, 5'd0, 5'd0, 32'd0, 32'd0, 3'd2, 1, 32'd0, val);
    endtask

    task automatic test_reset();
        rst = 1'b1; op_valid = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        AD1 = '0; AD2 = '0; AD3 = '0; ImmOp = '0; PC = '0; funct3 = '0;
        ALUctrl = '0; ALUsrc = 1'b0; ResultSrc = '0; RegWrite = 1'b0; MemWrite = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);
        vectors++;
        if (op_ready !== 1'b1 || mem_req !== 1'b0 || done !== 1'b0 || EQ !== 1'b0 ||
            ALUout !== 32'd0 || a0 !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: got ready=%b req=%b done=%b eq=%b aluout=%h a0=%h expected 1 0 0 0 0 0",
                     op_ready, mem_req, done, EQ, ALUout, a0);
        end
        rst = 1'b0;
    endtask

    task automatic test_alu_basic();
        logic [31:0] r;
        run_op(3'd0, 1'b1, 2'b00, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 32'd7, 32'd0, 3'd0, 1, 32'd0, r);
        run_op(3'd0, 1'b0, 2'b00, 1'b1, 1'b0, 5'd5, 5'd5, 5'd10, 32'd0, 32'd0, 3'd0, 1, 32'd0, r);
        vectors++;
        if (a0 !== 32'd14 || EQ !== 1'b0) begin
            errors++;
            $display("FAIL add_x10: got a0=%h eq=%b expected a0=0000000e eq=0", a0, EQ);
        end
        run_op(3'd1, 1'b0, 2'b00, 1'b1, 1'b0, 5'd5, 5'd5, 5'd6, 32'd0, 32'd0, 3'd0, 1, 32'd0, r);
        vectors++;
        if (r !== 32'd0 || EQ !== 1'b1) begin
            errors++;
            $display("FAIL sub_zero: got aluout=%h eq=%b expected 0 eq=1", r, EQ);
        end
        run_op(3'd0, 1'b1, 2'b11, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'd5, 32'd0, 3'd0, 1, 32'd0, r);
        probe(5'd0, r);
        vectors++;
        if (r !== 32'd0) begin
            errors++;
            $display("FAIL x0_write: got %h expected 00000000", r);
        end
    endtask

    task automatic test_mem();
        logic [31:0] r;
        run_op(3'd0, 1'b1, 2'b00, 1'b0, 1'b1, 5'd0, 5'd5, 5'd0, 32'h100, 32'd0, 3'b010, 3, 32'd0, r);
        run_op(3'd0, 1'b1, 2'b01, 1'b1, 1'b0, 5'd0, 5'd0, 5'd7, 32'h100, 32'd0, 3'b000, 3, 32'h000000F0, r);
        probe(5'd7, r);
        vectors++;
        if (r !== 32'hFFFFFFF0) begin
            errors++;
            $display("FAIL lb_sign: got %h expected fffffff0", r);
        end
        run_op(3'd0, 1'b1, 2'b01, 1'b1, 1'b0, 5'd0, 5'd0, 5'd8, 32'h100, 32'd0, 3'b100, 2, 32'h000000F0, r);
        probe(5'd8, r);
        vectors++;
        if (r !== 32'h000000F0) begin
            errors++;
            $display("FAIL lbu_zero: got %h expected 000000f0", r);
        end
        // Store with RegWrite and ResultSrc=01 set must not write rd.
        run_op(3'd0, 1'b1, 2'b01, 1'b1, 1'b1, 5'd7, 5'd8, 5'd9, 32'h20, 32'd0, 3'b010, 1, 32'hDEADBEEF, r);
        for (int i = 0; i < 10; i++) begin
            run_op(3'($urandom()), 1'b1, 2'b01, 1'b1, 1'b0, 5'($urandom()), 5'($urandom()),
                   5'($urandom_range(1, 31)), $urandom(), $urandom(), 3'($urandom()),
                   $urandom_range(1, 5), $urandom(), r);
        end
    endtask

    task automatic test_result_src();
        logic [31:0] r;
        run_op(3'd0, 1'b1, 2'b00, 1'b1, 1'b0, 5'd0, 5'd0, 5'd14, 32'd99, 32'd0, 3'd0, 1, 32'd0, r);
        run_op(3'd0, 1'b1, 2'b10, 1'b1, 1'b0, 5'd0, 5'd0, 5'd14, 32'd8, 32'hFFFFFFFC, 3'd0, 1, 32'd0, r);
        probe(5'd14, r);
        vectors++;
        if (r !== 32'd0) begin
            errors++;
            $display("FAIL pc4_wrap: got %h expected 00000000", r);
        end
        run_op(3'd0, 1'b1, 2'b11, 1'b1, 1'b0, 5'd0, 5'd0, 5'd11, 32'h12345000, 32'd0, 3'd0, 1, 32'd0, r);
        probe(5'd11, r);
        vectors++;
        if (r !== 32'h12345000) begin
            errors++;
            $display("FAIL imm_result: got %h expected 12345000", r);
        end
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic        mw;
        logic [1:0]  rs;
        for (int i = 0; i < 40; i++) begin
            mw = ($urandom_range(0, 4) == 0);
            rs = 2'($urandom());
            run_op(3'($urandom()), 1'($urandom()), rs, 1'($urandom_range(0, 3) != 0), mw,
                   5'($urandom()), 5'($urandom()), 5'($urandom()),
                   ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 40)),
                   $urandom(), 3'($urandom()), $urandom_range(1, 4), $urandom(), r);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r, sum, k;
        sum = 32'd0;
        run_op(3'd0, 1'b1, 2'b00, 1'b1, 1'b0, 5'd0, 5'd0, 5'd12, 32'd0, 32'd0, 3'd0, 1, 32'd0, r);
        for (int i = 0; i < 10; i++) begin
            k   = $urandom();
            sum = sum + k;
            run_op(3'd0, 1'b1, 2'b00, 1'b1, 1'b0, 5'd12, 5'd0, 5'd12, k, 32'd0, 3'd0, 1, 32'd0, r);
        end
        probe(5'd12, r);
        vectors++;
        if (r !== sum) begin
            errors++;
            $display("FAIL dependent_chain: got %h expected %h", r, sum);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        int          n;
        AD1 = 5'd0; AD2 = 5'd0; AD3 = 5'd13; ImmOp = 32'h40; PC = 32'd0; funct3 = 3'b010;
        ALUctrl = 3'd0; ALUsrc = 1'b1; ResultSrc = 2'b01; RegWrite = 1'b1; MemWrite = 1'b0;
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        mem_ack  = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mem_req !== 1'b1 && n < 10);
        @(negedge clk);
        vectors++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_setup: got mem_req=%b expected 1", mem_req);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
        @(negedge clk);
        vectors++;
        if (mem_req !== 1'b0 || op_ready !== 1'b1 || done !== 1'b0 || a0 !== 32'd0 ||
            ALUout !== 32'd0 || EQ !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got req=%b ready=%b done=%b a0=%h aluout=%h eq=%b expected 0 1 0 0 0 0",
                     mem_req, op_ready, done, a0, ALUout, EQ);
        end
        n = 0;
        for (int i = 0; i < 4; i++) begin
            mem_ack = 1'b1;
            @(negedge clk);
            if (done !== 1'b0 || mem_req !== 1'b0) n++;
        end
        mem_ack = 1'b0;
        vectors++;
        if (n != 0) begin
            errors++;
            $display("FAIL mid_reset_quiet: got %0d active cycles expected 0", n);
        end
        probe(5'd5, r);
        vectors++;
        if (r !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset_regs: got x5=%h expected 00000000", r);
        end
    endtask

    initial begin
        test_reset();
        test_alu_basic();
        test_mem();
        test_result_src();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
